// File: rtl/delay_tdc_avg.sv
// Time-to-digital converter that averages 2^AVG_LOG2 from->to edge delays per batch.
// Optional wait timeout is compiled in when DELAY_TDC_TIMEOUT_EN is defined.
module delay_tdc_avg #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             from_in,
    input  logic             to_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_delay,
    output logic             out_ovf,
    output logic             out_timeout
);

    localparam int unsigned AccW = CNT_W + AVG_LOG2;
    localparam int unsigned IdxW = AVG_LOG2 + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'((2 ** AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    if (CNT_W == 0 || TIMEOUT_CYC == 0) begin : g_param_check
        $error("delay_tdc_avg: CNT_W and TIMEOUT_CYC must be non-zero");
    end

    typedef enum logic [1:0] {
        StIdle,
        StWaitFrom,
        StWaitTo,
        StOutput
    } state_e;

    state_e state_q, state_d;

    // Input synchronisers and registered rising-edge detectors
    logic [1:0] from_sync_q, from_sync_d;
    logic [1:0] to_sync_q, to_sync_d;
    logic       from_prev_q, from_prev_d;
    logic       to_prev_q, to_prev_d;
    logic       from_edge_q, from_edge_d;
    logic       to_edge_q, to_edge_d;

    always_comb begin
        from_sync_d = {from_sync_q[0], from_in};
        to_sync_d   = {to_sync_q[0], to_in};
        from_prev_d = from_sync_q[1];
        to_prev_d   = to_sync_q[1];
        from_edge_d = from_sync_q[1] & ~from_prev_q;
        to_edge_d   = to_sync_q[1] & ~to_prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            from_sync_q <= '0;
            to_sync_q   <= '0;
            from_prev_q <= 1'b0;
            to_prev_q   <= 1'b0;
            from_edge_q <= 1'b0;
            to_edge_q   <= 1'b0;
        end else begin
            from_sync_q <= from_sync_d;
            to_sync_q   <= to_sync_d;
            from_prev_q <= from_prev_d;
            to_prev_q   <= to_prev_d;
            from_edge_q <= from_edge_d;
            to_edge_q   <= to_edge_d;
        end
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AccW-1:0]  acc_q, acc_d;
    logic [IdxW-1:0]  sample_idx_q, sample_idx_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] out_delay_q, out_delay_d;
    logic             out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             waiting;
    logic             awaited_edge;
    logic             last_sample;
    logic             load_out;
    logic             tmo_hit;
    logic             abort;

    assign waiting      = (state_q == StWaitFrom) || (state_q == StWaitTo);
    assign awaited_edge = ((state_q == StWaitFrom) && from_edge_q) ||
                          ((state_q == StWaitTo) && to_edge_q);
    assign last_sample  = (sample_idx_q == LastIdx);
    assign cnt_inc      = (cnt_q == CntMax) ? CntMax : cnt_q + CNT_W'(1);
    assign load_out     = (state_q != StOutput) && (state_d == StOutput);
    assign abort        = tmo_hit && !awaited_edge;

`ifdef DELAY_TDC_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            tmo_flag_q, tmo_flag_d;
    logic            out_timeout_q, out_timeout_d;

    assign tmo_hit = waiting && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

    // Wait counter restarts on every state change
    always_comb begin
        tmo_d = '0;
        if (waiting && (state_d == state_q)) begin
            tmo_d = tmo_q + TmoW'(1);
        end
        tmo_flag_d = tmo_flag_q;
        if ((state_q == StIdle) && start) begin
            tmo_flag_d = 1'b0;
        end
        if (abort) begin
            tmo_flag_d = 1'b1;
        end
        out_timeout_d = out_timeout_q;
        if (load_out) begin
            out_timeout_d = tmo_flag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q         <= '0;
            tmo_flag_q    <= 1'b0;
            out_timeout_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            tmo_flag_q    <= tmo_flag_d;
            out_timeout_q <= out_timeout_d;
        end
    end

    assign out_timeout = out_timeout_q;
`else
    assign tmo_hit     = 1'b0;
    assign out_timeout = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StWaitFrom;
            end
            StWaitFrom: begin
                if (from_edge_q) state_d = StWaitTo;
                else if (tmo_hit) state_d = StOutput;
            end
            StWaitTo: begin
                if (to_edge_q) state_d = last_sample ? StOutput : StWaitFrom;
                else if (tmo_hit) state_d = StOutput;
            end
            StOutput: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = (state_q != StIdle);
        out_valid = (state_q == StOutput);
    end

    // Datapath; the sample is cnt_inc so that adjacent-cycle edges measure 1
    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        sample_idx_d = sample_idx_q;
        ovf_d        = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d        = '0;
                    sample_idx_d = '0;
                    ovf_d        = 1'b0;
                end
            end
            StWaitFrom: begin
                if (from_edge_q) cnt_d = '0;
            end
            StWaitTo: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CntMax) ovf_d = 1'b1;
                if (to_edge_q) begin
                    acc_d        = acc_q + AccW'(cnt_inc);
                    sample_idx_d = sample_idx_q + IdxW'(1);
                end
            end
            default: ;
        endcase

        out_delay_d = out_delay_q;
        out_ovf_d   = out_ovf_q;
        if (load_out) begin
            out_delay_d = abort ? CntMax : CNT_W'(acc_d >> AVG_LOG2);
            out_ovf_d   = ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            sample_idx_q <= '0;
            ovf_q        <= 1'b0;
            out_delay_q  <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            sample_idx_q <= sample_idx_d;
            ovf_q        <= ovf_d;
            out_delay_q  <= out_delay_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    assign out_delay = out_delay_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_delay_tdc_avg.sv
// Scoreboard bench for delay_tdc_avg: batches of edge pairs, expected averages queued
// from a plain-arithmetic model and checked by an independent output monitor.
module tb_delay_tdc_avg;

    localparam int unsigned CntW = 16;
    localparam int unsigned SatVal = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        from_in = 1'b0;
    logic        to_in = 1'b0;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        out_valid;
    logic [15:0] out_delay;
    logic        out_ovf;
    logic        out_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] delay;
        logic        ovf;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];

    delay_tdc_avg #(
        .CNT_W      (CntW),
        .AVG_LOG2   (2),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .from_in    (from_in),
        .to_in      (to_in),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_delay  (out_delay),
        .out_ovf    (out_ovf),
        .out_timeout(out_timeout)
    );

    always #5 clk = ~clk;

    // Monitor: pops on every handshake, checks hold stability and single-pulse valid
    logic        prev_hold = 1'b0;
    logic        prev_hs = 1'b0;
    logic [15:0] held_delay;
    logic        held_ovf;
    logic        held_tmo;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
            prev_hs   = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (!out_valid || out_delay !== held_delay || out_ovf !== held_ovf ||
                    out_timeout !== held_tmo) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%0b delay=%0d ovf=%0b tmo=%0b, want 1/%0d/%0b/%0b",
                             out_valid, out_delay, out_ovf, out_timeout, held_delay, held_ovf,
                             held_tmo);
                end
            end
            if (prev_hs) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL valid_after_hs: got out_valid=%0b, want 0", out_valid);
                end
            end
            if (out_valid && out_ready) begin
                exp_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got delay=%0d, want no output", out_delay);
                end else begin
                    e = exp_q.pop_front();
                    if (out_delay !== e.delay || out_ovf !== e.ovf || out_timeout !== e.tmo) begin
                        errors++;
                        $display("FAIL result: got delay=%0d ovf=%0b tmo=%0b, want %0d/%0b/%0b",
                                 out_delay, out_ovf, out_timeout, e.delay, e.ovf, e.tmo);
                    end
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_hs    = out_valid && out_ready;
            held_delay = out_delay;
            held_ovf   = out_ovf;
            held_tmo   = out_timeout;
        end
    end

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b, want %0b", name, got, want);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // from_in rises, to_in rises d cycles later (each held high for one cycle)
    task automatic send_pair(input int d);
        @(posedge clk); #1 from_in = 1'b1;
        @(posedge clk); #1 from_in = 1'b0;
        repeat (d - 1) @(posedge clk);
        #1 to_in = 1'b1;
        @(posedge clk); #1 to_in = 1'b0;
    endtask

    task automatic run_batch(input int d0, input int d1, input int d2, input int d3);
        int    ds[4];
        longint sum;
        exp_t  e;
        ds  = '{d0, d1, d2, d3};
        sum = 0;
        e   = '0;
        foreach (ds[i]) begin
            if (ds[i] >= int'(SatVal)) begin
                sum   += SatVal;
                e.ovf = 1'b1;
            end else begin
                sum += ds[i];
            end
        end
        e.delay = 16'(sum / 4);
        exp_q.push_back(e);
        pulse_start();
        foreach (ds[i]) begin
            send_pair(ds[i]);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_bit(name, busy, 1'b0);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_bit(name, out_valid, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_valid", out_valid, 1'b0);
        check_val("rst_delay", out_delay, 16'd0);
        check_bit("rst_ovf", out_ovf, 1'b0);
        check_bit("rst_tmo", out_timeout, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        run_batch(10, 10, 10, 10);
        wait_idle("idle_4x10", 200);

        run_batch(10, 11, 12, 14);
        wait_idle("idle_mixed", 200);

        repeat (6) begin
            run_batch($urandom_range(1, 40), $urandom_range(1, 40),
                      $urandom_range(1, 40), $urandom_range(1, 40));
            wait_idle("idle_rand", 200);
        end

        // Consumer stalls with start pulsed while the result is held
        out_ready = 1'b0;
        run_batch($urandom_range(1, 30), $urandom_range(1, 30),
                  $urandom_range(1, 30), $urandom_range(1, 30));
        wait_valid("stall_valid", 200);
        @(posedge clk);
        pulse_start();
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_bit("stall_idle_busy", busy, 1'b0);
        check_bit("stall_idle_valid", out_valid, 1'b0);

        // Reset in the middle of a measurement
        pulse_start();
        @(posedge clk); #1 from_in = 1'b1;
        @(posedge clk); #1 from_in = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_bit("mid_busy_pre", busy, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_bit("mid_rst_busy", busy, 1'b0);
        check_bit("mid_rst_valid", out_valid, 1'b0);
        check_val("mid_rst_delay", out_delay, 16'd0);
        run_batch(10, 10, 10, 10);
        wait_idle("idle_post_rst", 200);

`ifdef DELAY_TDC_TIMEOUT_EN
        begin
            exp_t e;
            e.delay = 16'hFFFF;
            e.ovf   = 1'b0;
            e.tmo   = 1'b1;
            exp_q.push_back(e);
            pulse_start();
            @(posedge clk); #1 from_in = 1'b1;
            @(posedge clk); #1 from_in = 1'b0;
            wait_valid("tmo_valid", 300);
            wait_idle("idle_tmo", 50);
        end
`else
        run_batch(70000, 10, 10, 10);
        wait_idle("idle_sat", 200);
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL results_drained: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
